// File: rtl/count_gen_pkg.sv
// -----------------------------------------------------------------------------
// count_gen_pkg
// Shared definitions for count_generator:
//   state_t   - FSM state encoding (IDLE, LOAD, RUN, GAP)
//   INJ_MASK  - error-injection mask; cast down to DATA_W at the point of use
//   sat_inc32 - saturating 32-bit increment used for the beat counter output
// -----------------------------------------------------------------------------
package count_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Only bit 0 is flipped on an injected beat.
    localparam logic [63:0] INJ_MASK = 64'h1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/count_generator.sv
// -----------------------------------------------------------------------------
// count_generator
// Emits an incrementing count stream to a TX interface, optionally split into
// bursts separated by idle gaps, with single-word error injection.
//
// Ports:
//   clk_i            rising-edge clock
//   reset_i          synchronous active-high reset
//   start_i          level run enable; low returns to IDLE on the next edge
//   inject_err_i     one-cycle request to corrupt bit 0 of the next beat
//   tx_ready_i       downstream ready; a beat is issued only when high in RUN
//   seed_i           first count value (sampled in LOAD)
//   burst_len_i      beats per burst, 0 = continuous (sampled in LOAD)
//   gap_len_i        idle cycles between bursts (sampled in LOAD)
//   data_o           registered count word
//   usr_data_valid_o data_o valid this cycle
//   frame_start_o    first beat of a burst
//   tx_count_o       saturating count of beats issued since LOAD
//   busy_o           FSM not in IDLE
// -----------------------------------------------------------------------------
module count_generator
    import count_gen_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BURST_W = 16,
    parameter int unsigned GAP_W   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               inject_err_i,
    input  logic               tx_ready_i,
    input  logic [DATA_W-1:0]  seed_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic [GAP_W-1:0]   gap_len_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               usr_data_valid_o,
    output logic               frame_start_o,
    output logic [31:0]        tx_count_o,
    output logic               busy_o
);

    localparam logic [DATA_W-1:0] W_MASK = DATA_W'(INJ_MASK);

    state_t               r_state,     w_state;
    logic [DATA_W-1:0]    r_count,     w_count;
    logic [BURST_W-1:0]   r_beat,      w_beat;
    logic [GAP_W-1:0]     r_gap,       w_gap;
    logic [BURST_W-1:0]   r_burst_cfg, w_burst_cfg;
    logic [GAP_W-1:0]     r_gap_cfg,   w_gap_cfg;
    logic                 r_first,     w_first;
    logic                 r_pend,      w_pend;
    logic [DATA_W-1:0]    r_data,      w_data;
    logic                 r_valid,     w_valid;
    logic                 r_fs,        w_fs;
    logic [31:0]          r_tx_count,  w_tx_count;
    logic                 r_busy,      w_busy;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_beat      <= '0;
            r_gap       <= '0;
            r_burst_cfg <= '0;
            r_gap_cfg   <= '0;
            r_first     <= 1'b0;
            r_pend      <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_fs        <= 1'b0;
            r_tx_count  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_beat      <= w_beat;
            r_gap       <= w_gap;
            r_burst_cfg <= w_burst_cfg;
            r_gap_cfg   <= w_gap_cfg;
            r_first     <= w_first;
            r_pend      <= w_pend;
            r_data      <= w_data;
            r_valid     <= w_valid;
            r_fs        <= w_fs;
            r_tx_count  <= w_tx_count;
            r_busy      <= w_busy;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_count     = r_count;
        w_beat      = r_beat;
        w_gap       = r_gap;
        w_burst_cfg = r_burst_cfg;
        w_gap_cfg   = r_gap_cfg;
        w_first     = r_first;
        w_pend      = r_pend;
        w_data      = r_data;
        w_valid     = 1'b0;
        w_fs        = 1'b0;
        w_tx_count  = r_tx_count;

        if (!start_i) begin
            w_state = ST_IDLE;
            w_data  = '0;
            w_pend  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: w_state = ST_LOAD;
                ST_LOAD: begin
                    w_count     = seed_i;
                    w_beat      = burst_len_i;
                    w_gap       = gap_len_i;
                    w_burst_cfg = burst_len_i;
                    w_gap_cfg   = gap_len_i;
                    w_tx_count  = '0;
                    w_pend      = 1'b0;
                    w_first     = 1'b1;
                    w_state     = ST_RUN;
                end
                ST_RUN: begin
                    if (tx_ready_i) begin
                        w_valid    = 1'b1;
                        w_fs       = r_first;
                        w_first    = 1'b0;
                        w_data     = r_pend ? (r_count ^ W_MASK) : r_count;
                        w_count    = r_count + 1'b1;
                        w_tx_count = sat_inc32(r_tx_count);
                        // A pending flag is consumed by this beat and masks any
                        // coincident request; otherwise a coincident request
                        // arms the following beat.
                        w_pend     = r_pend ? 1'b0 : inject_err_i;
                        if (r_burst_cfg != '0) begin
                            if (r_beat == BURST_W'(1)) begin
                                if (r_gap_cfg != '0) begin
                                    w_state = ST_GAP;
                                    w_gap   = r_gap_cfg;
                                end else begin
                                    w_beat  = r_burst_cfg;
                                    w_first = 1'b1;
                                end
                            end else begin
                                w_beat = r_beat - 1'b1;
                            end
                        end
                    end else begin
                        w_pend = r_pend | inject_err_i;
                    end
                end
                ST_GAP: begin
                    w_pend = r_pend | inject_err_i;
                    if (r_gap <= GAP_W'(1)) begin
                        w_state = ST_RUN;
                        w_beat  = r_burst_cfg;
                        w_gap   = r_gap_cfg;
                        w_first = 1'b1;
                    end else begin
                        w_gap = r_gap - 1'b1;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end

        w_busy = (w_state != ST_IDLE);
    end

    assign data_o           = r_data;
    assign usr_data_valid_o = r_valid;
    assign frame_start_o    = r_fs;
    assign tx_count_o       = r_tx_count;
    assign busy_o           = r_busy;

endmodule
